// File: rtl/br_flow_demux_select_reg.sv
// br_flow_demux_select_reg
// Steers each beat of a single ready/valid flow to one of NumFlows outputs,
// chosen per beat by push_select. Every output has its own 2-entry buffer,
// so a stalled consumer only blocks beats that are headed to it.
// All pop outputs come straight from registers. push_ready depends only on
// push_select and registered state, never on pop_ready.
//
// Handshake: a beat moves on a rising clk edge when valid & ready are both
// high. A producer holds valid (and its payload) until that edge. Ready may
// be computed without looking at valid.

module br_flow_demux_select_reg #(
  parameter int NumFlows = 2,
  parameter int Width = 1,
  parameter bit EnableAssertPushValidStability = 1,
  parameter bit EnableAssertPushDataStability = EnableAssertPushValidStability,
  parameter bit EnableAssertFinalNotValid = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               push_ready,
  input  logic                               push_valid,
  input  logic [Width-1:0]                   push_data,
  input  logic [$clog2(NumFlows)-1:0]        push_select,
  input  logic [NumFlows-1:0]                pop_ready,
  output logic [NumFlows-1:0]                pop_valid,
  output logic [NumFlows-1:0][Width-1:0]     pop_data
);

  localparam int SelWidth = $clog2(NumFlows);

  // Low until the first clk edge after reset release, so push_ready cannot
  // rise while rst_n is low or in the same cycle that rst_n deasserts.
  logic init_done;

  // Per-output 2-entry FIFO: head feeds the pop side, tail is the second slot.
  logic [Width-1:0] head_q  [NumFlows];
  logic [Width-1:0] tail_q  [NumFlows];
  logic [1:0]       count_q [NumFlows];

  logic                sel_hit;
  logic                sel_full;
  logic [NumFlows-1:0] push_hit;
  logic [NumFlows-1:0] pop_fire;
  logic [NumFlows-1:0] count_inc;

  // Decode push_select against the output range and look up the target's fill level.
  always_comb begin
    sel_hit  = 1'b0;
    sel_full = 1'b0;
    for (int i = 0; i < NumFlows; i++) begin
      if (push_select == SelWidth'(i)) begin
        sel_hit  = 1'b1;
        sel_full = (count_q[i] == 2'd2);
      end
    end
  end

  assign push_ready = init_done && sel_hit && !sel_full;

  // Per-output push/pop strobes for this cycle.
  always_comb begin
    push_hit  = '0;
    pop_fire  = '0;
    count_inc = '0;
    for (int i = 0; i < NumFlows; i++) begin
      push_hit[i]  = push_valid && push_ready && (push_select == SelWidth'(i));
      pop_fire[i]  = pop_valid[i] && pop_ready[i];
      count_inc[i] = push_hit[i] && !pop_fire[i];
    end
  end

  // Reset-release tracker that gates push_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end

  // Per-output FIFO update. An empty slot is cleared to zero so that pop_data
  // reads zero whenever pop_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumFlows; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NumFlows; i++) begin
        case ({push_hit[i], pop_fire[i]})
          2'b10: begin
            // Push only. A full output never sees a push, because ready is low.
            if (count_q[i] == 2'd0) begin
              head_q[i]  <= push_data;
              count_q[i] <= 2'd1;
            end else begin
              tail_q[i]  <= push_data;
              count_q[i] <= 2'd2;
            end
          end
          2'b01: begin
            // Pop only: the tail moves up to the head, or the output drains.
            if (count_q[i] == 2'd2) begin
              head_q[i]  <= tail_q[i];
              tail_q[i]  <= '0;
              count_q[i] <= 2'd1;
            end else begin
              head_q[i]  <= '0;
              count_q[i] <= 2'd0;
            end
          end
          2'b11: begin
            // Push and pop on the same output. This only happens at count 1:
            // the new beat replaces the head and the count stays at 1.
            head_q[i] <= push_data;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Registered pop side.
  always_comb begin
    for (int i = 0; i < NumFlows; i++) begin
      pop_valid[i] = (count_q[i] != 2'd0);
      pop_data[i]  = head_q[i];
    end
  end

`ifndef SYNTHESIS
  if (EnableAssertPushValidStability) begin : g_a_push_valid
    a_push_valid_stable: assert property (@(posedge clk) disable iff (!rst_n)
      push_valid && !push_ready |=> push_valid);
  end

  if (EnableAssertPushDataStability) begin : g_a_push_data
    a_push_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
      push_valid && !push_ready |=> $stable(push_data) && $stable(push_select));
  end

  a_select_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    push_valid |-> sel_hit);

  a_one_increment: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(count_inc));

  for (genvar g = 0; g < NumFlows; g++) begin : g_a_count
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
      count_q[g] != 2'd3);
    c_output_full: cover property (@(posedge clk) disable iff (!rst_n)
      count_q[g] == 2'd2);
  end

  c_push_backpressure: cover property (@(posedge clk) disable iff (!rst_n)
    push_valid && !push_ready);

  c_push_pop_same: cover property (@(posedge clk) disable iff (!rst_n)
    |(push_hit & pop_fire));

  if (EnableAssertFinalNotValid) begin : g_a_final
    final begin
      a_final_not_valid: assert (pop_valid == '0);
    end
  end
`endif

endmodule
